multdiv_seq: RTL
================

// Module: multdiv_seq
// PURPOSE
//  Parametrised iterative multiplier/divider; successor to the fixed 32-bit multdiv unit.
//  Adds signed/unsigned mode, remainder output, an input-ready handshake and async reset.
//  Sits beside the ALU in the execute stage; the pipeline stalls while data_inputRDY=0.
//  Radix-2, one partial product / quotient bit per clock.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
// PORTS
//  clock           in   1      single clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  data_operandA   in   WIDTH  multiplicand / dividend
//  data_operandB   in   WIDTH  multiplier / divisor
//  ctrl_MULT       in   1      start multiply; sampled only when data_inputRDY=1
//  ctrl_DIV        in   1      start divide; sampled only when data_inputRDY=1
//  ctrl_unsigned   in   1      1 = unsigned operands, 0 = two's complement; captured with start
//  data_result     out  WIDTH  low WIDTH bits of product, or quotient
//  data_remainder  out  WIDTH  division remainder (sign of dividend); 0 after a multiply
//  data_exception  out  1      overflow, divide-by-zero or illegal start; valid with data_resultRDY
//  data_resultRDY  out  1      one-cycle pulse: result/remainder/exception valid
//  data_inputRDY   out  1      1 = idle, a new start is accepted this cycle
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; all outputs 0 except data_inputRDY=1; in-flight op discarded.
//  FSM states: IDLE, MUL, DIV, FIX, DONE.
//   IDLE: operands, mode and op captured at the start edge (edge 0) -> MUL or DIV; data_inputRDY=0.
//   MUL/DIV: WIDTH iterations on absolute values, counter WIDTH-1 down to 0 -> FIX.
//   FIX: apply result/remainder signs, evaluate exception -> DONE.
//   DONE: data_resultRDY=1 for exactly one cycle -> IDLE (data_inputRDY=1 again in that same cycle).
//  Latency: data_resultRDY high in the cycle after edge WIDTH+2 (after edge 34 for WIDTH=32).
//  data_result / data_remainder / data_exception hold their value until the next accepted start.
//  Multiply: full 2*WIDTH product formed internally; exception if it does not fit in WIDTH.
//   Signed: upper WIDTH+1 bits not all equal. Unsigned: upper WIDTH bits nonzero.
//  Divide: truncate toward zero; remainder carries the dividend's sign; |rem| < |divisor|.
//   Divisor == 0: no iteration; FSM IDLE->DONE, data_resultRDY in cycle after edge 1,
//    quotient = all ones, remainder = dividend, exception=1.
//   Signed MIN / -1: quotient = MIN, remainder = 0, exception=1; normal latency.
//  ctrl_MULT & ctrl_DIV together in IDLE: illegal. IDLE->DONE; result=0, remainder=0,
//   exception=1, data_resultRDY in cycle after edge 1.
//  Start asserted while data_inputRDY=0: ignored. No queuing, no effect on the in-flight op.
//  Operand inputs may change freely after the start edge.
// STRUCTURE
//  Shared package multdiv_pkg: state encoding (IDLE..DONE), op codes OP_MUL/OP_DIV/OP_ILL,
//   helper function for signed abs / conditional negate.
//  One sub-module: multdiv_step, combinational single iteration (add-shift for MUL,
//   restoring subtract-shift for DIV), parametrised by WIDTH.
//  Top: FSM, iteration counter, accumulator/remainder registers, sign fix-up, output registers.
// TESTING  (WIDTH=32 unless noted)
//  1 MUL signed -7 * 6 -> result 0xFFFFFFD6 (-42), exception 0, RDY after edge 34, inputRDY low edges 1..33.
//  2 MUL signed 0x00010000 * 0x00010000 -> result 0, exception 1. Unsigned 0xFFFFFFFF*1 -> 0xFFFFFFFF, exc 0.
//  3 DIV signed -7 / 2 -> quotient -3, remainder -1; unsigned 0xFFFFFFF9 / 2 -> 0x7FFFFFFC, rem 1.
//  4 DIV 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, exception 1, RDY after edge 1;
//    DIV 0x80000000 / -1 signed -> quotient 0x80000000, rem 0, exc 1.
//  5 Start MUL, pulse ctrl_DIV at edge 10 -> ignored, MUL result unchanged;
//    both ctrls in IDLE -> exc 1, result 0.
//  6 Deassert reset_n mid-DIV (edge 15) -> outputs 0 immediately, data_inputRDY=1;
//    new DIV 100/7 -> quotient 14, remainder 2.
//  Random: WIDTH=8 and 32, compare against a behavioural model; RDY exactly once per accepted start.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiplier/divider.
package multdiv_pkg;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_ILL} op_t;

    // Working width for the sign helper; supports WIDTH up to 64 (2*WIDTH products).
    localparam int unsigned MD_MAXW = 128;
    typedef logic [MD_MAXW-1:0] md_word_t;

    // Two's-complement negate when neg=1. Callers zero-extend into md_word_t and
    // truncate the result back, which is exact modulo 2^width.
    function automatic md_word_t cond_neg(input md_word_t v, input logic neg);
        return neg ? (~v + md_word_t'(1)) : v;
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// One radix-2 iteration: add-shift for multiply, restoring subtract-shift for divide.
// hi/lo form a 2*WIDTH shift pair; lo starts as |A|, hi as 0.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             op_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply: conditionally add, then shift the pair right with the carry.
    // Divide: shift the pair left, keep the trial difference when it does not borrow.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        hi_nxt  = sum[WIDTH:1];
        lo_nxt  = {sum[0], lo[WIDTH-1:1]};
        if (op_div) begin
            if (!diff[WIDTH]) begin
                hi_nxt = diff[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed/unsigned multiplier/divider with input-ready handshake.
// Iterates on magnitudes; signs are applied in FIX, outputs registered in DONE.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_unsigned,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_inputRDY
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned DW = 2 * WIDTH;

    state_t           state;
    op_t              op_q;
    logic             uns_q, a_neg_q, b_neg_q, ovf_q, exc_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, opb;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    logic             a_neg, b_neg, min_by_m1, res_neg, mul_exc;
    logic [WIDTH-1:0] a_abs, b_abs, quot_fix, rem_fix;
    logic [DW-1:0]    prod_s;

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .op_div  (state == DIV),
        .hi      (hi),
        .lo      (lo),
        .operand (opb),
        .hi_nxt  (hi_nxt),
        .lo_nxt  (lo_nxt)
    );

    // Operand magnitudes at the start edge, and signed sign fix-up of the finished magnitudes.
    always_comb begin
        a_neg     = ~ctrl_unsigned & data_operandA[WIDTH-1];
        b_neg     = ~ctrl_unsigned & data_operandB[WIDTH-1];
        a_abs     = WIDTH'(cond_neg(md_word_t'(data_operandA), a_neg));
        b_abs     = WIDTH'(cond_neg(md_word_t'(data_operandB), b_neg));
        min_by_m1 = ~ctrl_unsigned & (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                    & (data_operandB == '1);
        res_neg   = ~uns_q & (a_neg_q ^ b_neg_q);
        prod_s    = DW'(cond_neg(md_word_t'({hi, lo}), res_neg));
        mul_exc   = uns_q ? (|hi)
                          : ~((&prod_s[DW-1:WIDTH-1]) | ~(|prod_s[DW-1:WIDTH-1]));
        quot_fix  = WIDTH'(cond_neg(md_word_t'(lo), res_neg));
        rem_fix   = WIDTH'(cond_neg(md_word_t'(hi), a_neg_q));
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            op_q           <= OP_MUL;
            uns_q          <= 1'b0;
            a_neg_q        <= 1'b0;
            b_neg_q        <= 1'b0;
            ovf_q          <= 1'b0;
            exc_q          <= 1'b0;
            cnt            <= '0;
            hi             <= '0;
            lo             <= '0;
            opb            <= '0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            data_inputRDY  <= 1'b1;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_MULT | ctrl_DIV) begin
                        data_inputRDY <= 1'b0;
                        uns_q         <= ctrl_unsigned;
                        a_neg_q       <= a_neg;
                        b_neg_q       <= b_neg;
                        ovf_q         <= min_by_m1;
                        exc_q         <= 1'b0;
                        opb           <= b_abs;
                        lo            <= a_abs;
                        hi            <= '0;
                        cnt           <= CW'(WIDTH - 1);
                        if (ctrl_MULT & ctrl_DIV) begin
                            op_q  <= OP_ILL;
                            lo    <= '0;
                            exc_q <= 1'b1;
                            state <= DONE;
                        end else if (ctrl_MULT) begin
                            op_q  <= OP_MUL;
                            state <= MUL;
                        end else if (data_operandB == '0) begin
                            // Divide-by-zero short-circuits straight to DONE.
                            op_q  <= OP_DIV;
                            lo    <= '1;
                            hi    <= data_operandA;
                            exc_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            op_q  <= OP_DIV;
                            state <= DIV;
                        end
                    end
                end
                MUL, DIV: begin
                    hi <= hi_nxt;
                    lo <= lo_nxt;
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    if (op_q == OP_MUL) begin
                        lo    <= prod_s[WIDTH-1:0];
                        hi    <= '0;
                        exc_q <= mul_exc;
                    end else begin
                        lo    <= quot_fix;
                        hi    <= rem_fix;
                        exc_q <= ovf_q;
                    end
                    state <= DONE;
                end
                DONE: begin
                    data_result    <= lo;
                    data_remainder <= hi;
                    data_exception <= exc_q;
                    data_resultRDY <= 1'b1;
                    data_inputRDY  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
